execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the integer pipeline. It sits directly downstream of the operand-forwarding block and directly upstream of the memory-access stage. It registers forwarded operands and computes single-cycle ALU results, or runs an iterative multiply. It presents rd address, write-enable, data and a result-valid flag that the forwarding block uses for ALU-to-decode bypass and load/multiply stall detection.

## Interface
- DWIDTH, 32, datapath width
- AWIDTH, 5, register address width
- OPWIDTH, 4, ALU opcode width
- h_clk  in  1  clock
- h_rst  in  1  reset; asynchronous, active-low
- h_i_ce  in  1  upstream instruction present
- h_i_force_stall  in  1  forwarding stall; incoming operands not usable
- h_i_stall  in  1  memory stage cannot accept
- h_i_flush  in  1  kill the in-flight instruction
- h_i_opcode  in  OPWIDTH  ALU operation
- h_i_rs1_data, h_i_rs2_data  in  DWIDTH  forwarded operands
- h_i_imm  in  DWIDTH  immediate
- h_i_use_imm  in  1  operand B = imm instead of rs2
- h_i_addr_rd  in  AWIDTH  destination register
- h_i_we_reg  in  1  instruction writes rd
- h_o_ce  out  1  instruction present toward memory stage
- h_o_valid  out  1  h_o_data_rd is final
- h_o_we_reg  out  1  rd write enable
- h_o_addr_rd  out  AWIDTH  destination register
- h_o_data_rd  out  DWIDTH  result
- h_o_stall  out  1  stage cannot accept; equals busy OR h_i_stall

## Operation
- Opcodes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, MUL=10. Codes 11–15 produce result 0 with valid=1.
- Operand B is h_i_imm if h_i_use_imm is set, otherwise h_i_rs2_data.
- Shifts use B[$clog2(DWIDTH)-1:0]. SLT is a signed compare and SLTU is unsigned; both return 1 or 0, zero-extended.
- ADD, SUB and MUL wrap modulo 2^DWIDTH. MUL keeps the low DWIDTH bits, which are identical for signed and unsigned operands.
- Accept condition: h_i_ce & !h_i_force_stall & !h_o_stall & !h_i_flush.
- Bubble condition: h_i_force_stall, or h_i_ce=0, with the stage not stalled. In that case h_o_ce<=0 and h_o_valid<=0.
- h_o_we_reg is forced to 0 when h_i_addr_rd==0.
- State machine:
  - IDLE: accept a non-MUL op and load the output registers with valid=1; remain in IDLE. Accept a MUL op and load ce=1, valid=0 and rd/we; go to MUL.
  - MUL: one shift-add iteration per cycle, DWIDTH iterations in total. On the last iteration, write the result with valid=1 and return to IDLE.
- h_i_stall in IDLE with output present: hold all outputs unchanged. In MUL, iterations continue regardless of h_i_stall.
- h_i_flush: at the next edge h_o_ce<=0, h_o_valid<=0 and h_o_we_reg<=0, any MUL is aborted, and the state goes to IDLE. Flush has priority over stall and accept.

## Timing
- Reset (async assert): h_o_ce=0, h_o_valid=0, h_o_we_reg=0, h_o_addr_rd=0, h_o_data_rd=0, state IDLE, counter 0. h_o_stall then follows h_i_stall only.
- Single-cycle op accepted at edge T: the result is visible after T, with latency 1.
- MUL accepted at edge T: from T+1, h_o_ce=1, h_o_valid=0 and h_o_stall=1. h_o_valid rises after edge T+DWIDTH, and h_o_stall falls in the same cycle unless h_i_stall is high. The next accept is at T+DWIDTH+1 at the earliest.
- Reset asserted mid-MUL returns the stage to reset values immediately; no partial result is emitted.
- Flush and MUL completion on the same edge: flush wins and the result is discarded.

## Structure
- Shared header alu_defs.vh holds the opcode constants ALU_ADD … ALU_MUL, `ifndef-guarded, for reuse by the decoder.
- Sub-module mul_iter is the iterative shift-add multiplier.
  - Ports: start, a, b, abort, busy, done, product.
  - Counter width: $clog2(DWIDTH)+1.
- execute_stage holds the state machine, the single-cycle ALU and the output registers.

## Test plan
- ADD rs1=5, rs2=7, rd=3 -> one cycle later: ce=1, valid=1, we=1, addr=3, data=0x0000000C.
- SUB 0-1 -> 0xFFFFFFFF. SRA 0x80000000 by imm 4 -> 0xF8000000. SLTU 1<0xFFFFFFFF -> 1. SLT 1<0xFFFFFFFF -> 0.
- MUL 3 × 0xFFFFFFFE -> valid=0 with stall=1 for 31 cycles after accept, then valid=1 with data=0xFFFFFFFA after edge T+32.
- Flush at the 10th MUL iteration -> next cycle ce=0, valid=0, stall=0; a following ADD is accepted normally.
- Downstream stall and forwarding stall:
  - h_i_stall held 3 cycles after an ADD result -> outputs held; an upstream instruction is not accepted until the stall drops.
  - h_i_force_stall with h_i_ce=1 -> next cycle ce=0, valid=0 (bubble).
- ADD with rd=0 -> we=0. Async reset mid-MUL -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcode encodings (also used by
// the decoder) and the stage state type.
package execute_stage_pkg;

   localparam int unsigned ALU_ADD  = 0;
   localparam int unsigned ALU_SUB  = 1;
   localparam int unsigned ALU_SLL  = 2;
   localparam int unsigned ALU_SLT  = 3;
   localparam int unsigned ALU_SLTU = 4;
   localparam int unsigned ALU_XOR  = 5;
   localparam int unsigned ALU_SRL  = 6;
   localparam int unsigned ALU_SRA  = 7;
   localparam int unsigned ALU_OR   = 8;
   localparam int unsigned ALU_AND  = 9;
   localparam int unsigned ALU_MUL  = 10;

   typedef enum logic {
      ST_IDLE,
      ST_MUL
   } ex_state_e;

endpackage

// File: rtl/execute_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, DWIDTH cycles,
// low DWIDTH bits of the product.
module mul_iter #(
   parameter int unsigned DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DWIDTH-1:0] a,
   input  logic [DWIDTH-1:0] b,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [DWIDTH-1:0] product
);

   localparam int unsigned CW = $clog2(DWIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(DWIDTH - 1);

   logic [DWIDTH-1:0] r_a;
   logic [DWIDTH-1:0] r_b;
   logic [DWIDTH-1:0] r_acc;
   logic [CW-1:0]     r_cnt;
   logic              r_busy;
   logic [DWIDTH-1:0] w_acc_next;

   assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
   assign busy       = r_busy;
   assign done       = r_busy && (r_cnt == LAST);
   // product is taken combinationally on the final iteration so the result
   // lands in the stage output register on the same edge
   assign product    = w_acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (abort) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (start) begin
         r_a    <= a;
         r_b    <= b;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_acc <= w_acc_next;
         r_a   <= r_a << 1;
         r_b   <= r_b >> 1;
         if (done) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: registers forwarded operands, computes single-cycle ALU
// results, or sequences an iterative multiply.
module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int unsigned DWIDTH  = 32,
   parameter int unsigned AWIDTH  = 5,
   parameter int unsigned OPWIDTH = 4
) (
   input  logic               h_clk,
   input  logic               h_rst,
   input  logic               h_i_ce,
   input  logic               h_i_force_stall,
   input  logic               h_i_stall,
   input  logic               h_i_flush,
   input  logic [OPWIDTH-1:0] h_i_opcode,
   input  logic [DWIDTH-1:0]  h_i_rs1_data,
   input  logic [DWIDTH-1:0]  h_i_rs2_data,
   input  logic [DWIDTH-1:0]  h_i_imm,
   input  logic               h_i_use_imm,
   input  logic [AWIDTH-1:0]  h_i_addr_rd,
   input  logic               h_i_we_reg,
   output logic               h_o_ce,
   output logic               h_o_valid,
   output logic               h_o_we_reg,
   output logic [AWIDTH-1:0]  h_o_addr_rd,
   output logic [DWIDTH-1:0]  h_o_data_rd,
   output logic               h_o_stall
);

   localparam int unsigned SHW = $clog2(DWIDTH);

   ex_state_e          r_state;
   ex_state_e          w_state_next;
   logic               r_ce;
   logic               r_valid;
   logic               r_we;
   logic [AWIDTH-1:0]  r_addr;
   logic [DWIDTH-1:0]  r_data;

   logic [DWIDTH-1:0]  w_opb;
   logic [SHW-1:0]     w_shamt;
   logic [DWIDTH-1:0]  w_alu;
   logic               w_accept;
   logic               w_is_mul;
   logic               w_we;
   logic               w_mul_start;
   logic               w_mul_busy;
   logic               w_mul_done;
   logic [DWIDTH-1:0]  w_mul_product;

   assign w_opb       = h_i_use_imm ? h_i_imm : h_i_rs2_data;
   assign w_shamt     = w_opb[SHW-1:0];
   assign w_is_mul    = (h_i_opcode == OPWIDTH'(ALU_MUL));
   assign w_we        = h_i_we_reg && (h_i_addr_rd != '0);
   assign h_o_stall   = w_mul_busy | h_i_stall;
   assign w_accept    = h_i_ce && !h_i_force_stall && !h_o_stall && !h_i_flush;
   assign w_mul_start = w_accept && w_is_mul;

   assign h_o_ce      = r_ce;
   assign h_o_valid   = r_valid;
   assign h_o_we_reg  = r_we;
   assign h_o_addr_rd = r_addr;
   assign h_o_data_rd = r_data;

   always_comb begin
      w_alu = '0;
      case (h_i_opcode)
         OPWIDTH'(ALU_ADD):  w_alu = h_i_rs1_data + w_opb;
         OPWIDTH'(ALU_SUB):  w_alu = h_i_rs1_data - w_opb;
         OPWIDTH'(ALU_SLL):  w_alu = h_i_rs1_data << w_shamt;
         OPWIDTH'(ALU_SLT):  w_alu = {{(DWIDTH-1){1'b0}}, ($signed(h_i_rs1_data) < $signed(w_opb))};
         OPWIDTH'(ALU_SLTU): w_alu = {{(DWIDTH-1){1'b0}}, (h_i_rs1_data < w_opb)};
         OPWIDTH'(ALU_XOR):  w_alu = h_i_rs1_data ^ w_opb;
         OPWIDTH'(ALU_SRL):  w_alu = h_i_rs1_data >> w_shamt;
         OPWIDTH'(ALU_SRA):  w_alu = $unsigned($signed(h_i_rs1_data) >>> w_shamt);
         OPWIDTH'(ALU_OR):   w_alu = h_i_rs1_data | w_opb;
         OPWIDTH'(ALU_AND):  w_alu = h_i_rs1_data & w_opb;
         default:            w_alu = '0;
      endcase
   end

   mul_iter #(
      .DWIDTH (DWIDTH)
   ) u_mul (
      .clk     (h_clk),
      .rst_n   (h_rst),
      .start   (w_mul_start),
      .a       (h_i_rs1_data),
      .b       (w_opb),
      .abort   (h_i_flush),
      .busy    (w_mul_busy),
      .done    (w_mul_done),
      .product (w_mul_product)
   );

   always_ff @(posedge h_clk or negedge h_rst) begin
      if (!h_rst) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
         ST_MUL:  if (h_i_flush || w_mul_done) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Flush outranks everything; an idle stage under downstream stall holds.
   always_ff @(posedge h_clk or negedge h_rst) begin
      if (!h_rst) begin
         r_ce    <= 1'b0;
         r_valid <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (h_i_flush) begin
         r_ce    <= 1'b0;
         r_valid <= 1'b0;
         r_we    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_ce    <= 1'b1;
                  r_valid <= !w_is_mul;
                  r_we    <= w_we;
                  r_addr  <= h_i_addr_rd;
                  r_data  <= w_alu;
               end else if (!h_i_stall) begin
                  r_ce    <= 1'b0;
                  r_valid <= 1'b0;
               end
            end
            ST_MUL: begin
               if (w_mul_done) begin
                  r_valid <= 1'b1;
                  r_data  <= w_mul_product;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expected results,
// an independent monitor pops them whenever a new valid result appears.
module tb_execute_stage;
   import execute_stage_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned OW = 4;

   logic          h_clk;
   logic          h_rst;
   logic          h_i_ce;
   logic          h_i_force_stall;
   logic          h_i_stall;
   logic          h_i_flush;
   logic [OW-1:0] h_i_opcode;
   logic [DW-1:0] h_i_rs1_data;
   logic [DW-1:0] h_i_rs2_data;
   logic [DW-1:0] h_i_imm;
   logic          h_i_use_imm;
   logic [AW-1:0] h_i_addr_rd;
   logic          h_i_we_reg;
   logic          h_o_ce;
   logic          h_o_valid;
   logic          h_o_we_reg;
   logic [AW-1:0] h_o_addr_rd;
   logic [DW-1:0] h_o_data_rd;
   logic          h_o_stall;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic stall_edge = 1'b0;
   logic prev_valid = 1'b0;

   execute_stage #(
      .DWIDTH  (DW),
      .AWIDTH  (AW),
      .OPWIDTH (OW)
   ) dut (
      .h_clk           (h_clk),
      .h_rst           (h_rst),
      .h_i_ce          (h_i_ce),
      .h_i_force_stall (h_i_force_stall),
      .h_i_stall       (h_i_stall),
      .h_i_flush       (h_i_flush),
      .h_i_opcode      (h_i_opcode),
      .h_i_rs1_data    (h_i_rs1_data),
      .h_i_rs2_data    (h_i_rs2_data),
      .h_i_imm         (h_i_imm),
      .h_i_use_imm     (h_i_use_imm),
      .h_i_addr_rd     (h_i_addr_rd),
      .h_i_we_reg      (h_i_we_reg),
      .h_o_ce          (h_o_ce),
      .h_o_valid       (h_o_valid),
      .h_o_we_reg      (h_o_we_reg),
      .h_o_addr_rd     (h_o_addr_rd),
      .h_o_data_rd     (h_o_data_rd),
      .h_o_stall       (h_o_stall)
   );

   initial h_clk = 1'b0;
   always #5 h_clk = ~h_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // A held result (valid stays high across a stalled edge) is not a new one.
   always @(posedge h_clk) stall_edge <= h_i_stall;

   always @(negedge h_clk) begin : monitor
      exp_t e;
      if (h_o_valid && !(prev_valid && stall_edge)) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got addr %0d data %h expected none", h_o_addr_rd, h_o_data_rd);
         end else begin
            e = sb.pop_front();
            chk("sb_ce",   32'(h_o_ce),      32'd1);
            chk("sb_we",   32'(h_o_we_reg),  32'(e.we));
            chk("sb_addr", 32'(h_o_addr_rd), 32'(e.addr));
            chk("sb_data", h_o_data_rd,      e.data);
         end
      end
      prev_valid = h_o_valid;
   end

   task automatic tick();
      @(posedge h_clk);
      #1;
   endtask

   task automatic drive(input int unsigned op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] imm, input logic ui, input logic [AW-1:0] rd,
                        input logic we);
      h_i_ce       = 1'b1;
      h_i_opcode   = OW'(op);
      h_i_rs1_data = a;
      h_i_rs2_data = b;
      h_i_imm      = imm;
      h_i_use_imm  = ui;
      h_i_addr_rd  = rd;
      h_i_we_reg   = we;
   endtask

   task automatic idle();
      h_i_ce      = 1'b0;
      h_i_use_imm = 1'b0;
      h_i_we_reg  = 1'b0;
   endtask

   task automatic push(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      exp_t e;
      e.we   = we;
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic run_vec(input int unsigned op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] imm, input logic ui, input logic [AW-1:0] rd,
                          input logic exp_we, input logic [DW-1:0] exp_data);
      drive(op, a, b, imm, ui, rd, 1'b1);
      push(exp_we, rd, exp_data);
      tick();
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_ce"},    32'(h_o_ce),      32'd0);
      chk({name, "_valid"}, 32'(h_o_valid),   32'd0);
      chk({name, "_we"},    32'(h_o_we_reg),  32'd0);
   endtask

   initial begin
      h_rst = 1'b0;
      h_i_force_stall = 1'b0;
      h_i_stall = 1'b0;
      h_i_flush = 1'b0;
      h_i_opcode = '0;
      h_i_rs1_data = '0;
      h_i_rs2_data = '0;
      h_i_imm = '0;
      idle();
      h_i_addr_rd = '0;

      #3;
      chk_quiet("rst");
      chk("rst_addr", 32'(h_o_addr_rd), 32'd0);
      chk("rst_data", h_o_data_rd, 32'd0);
      h_i_stall = 1'b1;
      #1 chk("rst_stall_follow_hi", 32'(h_o_stall), 32'd1);
      h_i_stall = 1'b0;
      #1 chk("rst_stall_follow_lo", 32'(h_o_stall), 32'd0);
      tick();
      tick();
      h_rst = 1'b1;
      tick();

      // single-cycle ALU vectors, back to back
      run_vec(ALU_ADD,  32'd5,        32'd7,        32'd0, 1'b0, 5'd3,  1'b1, 32'h0000000C);
      run_vec(ALU_SUB,  32'd0,        32'd1,        32'd0, 1'b0, 5'd4,  1'b1, 32'hFFFFFFFF);
      run_vec(ALU_SRA,  32'h80000000, 32'd0,        32'd4, 1'b1, 5'd5,  1'b1, 32'hF8000000);
      run_vec(ALU_SLTU, 32'd1,        32'hFFFFFFFF, 32'd0, 1'b0, 5'd6,  1'b1, 32'h00000001);
      run_vec(ALU_SLT,  32'd1,        32'hFFFFFFFF, 32'd0, 1'b0, 5'd7,  1'b1, 32'h00000000);
      run_vec(ALU_SLL,  32'd1,        32'h0000003F, 32'd0, 1'b0, 5'd1,  1'b1, 32'h80000000);
      run_vec(ALU_SRL,  32'h80000000, 32'd4,        32'd0, 1'b0, 5'd2,  1'b1, 32'h08000000);
      run_vec(ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 5'd15, 1'b1, 32'h0FF00FF0);
      run_vec(ALU_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'd0, 1'b0, 5'd16, 1'b1, 32'hFFFFF0F0);
      run_vec(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 5'd17, 1'b1, 32'hF000F000);
      run_vec(12,       32'h12345678, 32'h9ABCDEF0, 32'd0, 1'b0, 5'd18, 1'b1, 32'h00000000);
      run_vec(ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'd0, 1'b0, 5'd19, 1'b1, 32'h00000000);
      run_vec(ALU_ADD,  32'd1,        32'd2,        32'd0, 1'b0, 5'd0,  1'b0, 32'h00000003);
      idle();
      tick();
      chk("bubble_after_vecs_valid", 32'(h_o_valid), 32'd0);

      // multiply: 3 * 0xFFFFFFFE
      drive(ALU_MUL, 32'd3, 32'hFFFFFFFE, 32'd0, 1'b0, 5'd8, 1'b1);
      push(1'b1, 5'd8, 32'hFFFFFFFA);
      tick();
      idle();
      chk("mul_start_ce",    32'(h_o_ce),    32'd1);
      chk("mul_start_valid", 32'(h_o_valid), 32'd0);
      chk("mul_start_stall", 32'(h_o_stall), 32'd1);
      for (int k = 1; k <= 31; k++) begin
         tick();
         chk("mul_busy_valid", 32'(h_o_valid), 32'd0);
         chk("mul_busy_stall", 32'(h_o_stall), 32'd1);
      end
      tick();
      chk("mul_done_valid", 32'(h_o_valid), 32'd1);
      chk("mul_done_stall", 32'(h_o_stall), 32'd0);
      tick();

      // flush at the 10th multiply iteration
      drive(ALU_MUL, 32'd5, 32'd7, 32'd0, 1'b0, 5'd9, 1'b1);
      tick();
      idle();
      repeat (9) tick();
      h_i_flush = 1'b1;
      tick();
      h_i_flush = 1'b0;
      chk_quiet("flush");
      chk("flush_stall", 32'(h_o_stall), 32'd0);
      run_vec(ALU_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 5'd10, 1'b1, 32'h00000005);
      idle();
      repeat (40) tick();

      // downstream stall holds the result and blocks the next instruction
      run_vec(ALU_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 5'd11, 1'b1, 32'd30);
      h_i_stall = 1'b1;
      drive(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd12, 1'b1);
      push(1'b1, 5'd12, 32'd2);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("hold_valid", 32'(h_o_valid),   32'd1);
         chk("hold_addr",  32'(h_o_addr_rd), 32'd11);
         chk("hold_data",  h_o_data_rd,      32'd30);
         chk("hold_stall", 32'(h_o_stall),   32'd1);
      end
      h_i_stall = 1'b0;
      tick();
      chk("release_addr", 32'(h_o_addr_rd), 32'd12);

      // forwarding stall inserts a bubble
      drive(ALU_ADD, 32'd4, 32'd4, 32'd0, 1'b0, 5'd13, 1'b1);
      h_i_force_stall = 1'b1;
      tick();
      chk("fstall_ce",    32'(h_o_ce),    32'd0);
      chk("fstall_valid", 32'(h_o_valid), 32'd0);
      h_i_force_stall = 1'b0;
      push(1'b1, 5'd13, 32'd8);
      tick();
      idle();
      tick();

      // asynchronous reset in the middle of a multiply
      drive(ALU_MUL, 32'd3, 32'd3, 32'd0, 1'b0, 5'd14, 1'b1);
      tick();
      idle();
      repeat (5) tick();
      #2 h_rst = 1'b0;
      #1;
      chk_quiet("amid_rst");
      chk("amid_rst_addr",  32'(h_o_addr_rd), 32'd0);
      chk("amid_rst_data",  h_o_data_rd,      32'd0);
      chk("amid_rst_stall", 32'(h_o_stall),   32'd0);
      tick();
      h_rst = 1'b1;
      repeat (40) tick();
      run_vec(ALU_ADD, 32'd6, 32'd7, 32'd0, 1'b0, 5'd20, 1'b1, 32'h0000000D);
      idle();
      tick();
      tick();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
